// File: rtl/lifo.sv
// Register-array LIFO stack with a registered pop output.
// Push and pop together on a non-empty stack replace the top entry.
module lifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_S = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp;
    logic [AW-1:0]    top;

    // Low bits of sp-1 wrap to DEPTH-1 when the stack is full.
    assign top   = sp[AW-1:0] - ONE_A;
    assign full  = (sp == FULL_N);
    assign empty = (sp == '0);
    assign count = sp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp       <= '0;
            data_out <= '0;
        end else if (pop && !empty) begin
            data_out <= mem[top];
            if (!push) begin
                sp <= sp - ONE_S;
            end
        end else if (push && !full) begin
            sp <= sp + ONE_S;
        end
    end

    // Contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            if (pop && !empty) begin
                mem[top] <= data_in;
            end else if (!full) begin
                mem[sp[AW-1:0]] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_lifo.sv
// Directed self-checking bench for the lifo stack.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [3:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    lifo #(.DEPTH(8), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        tick(); tick();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", full); end
        reset = 1'b1;
        tick();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_rel_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_rel_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_rel_full: got %b want 0", full); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rst_rel_dout: got %h want 00", data_out); end
    endtask

    task automatic test_order;
        logic [7:0] vals [4] = '{8'h11, 8'h11, 8'h22, 8'h33};
        logic [7:0] exp [3] = '{8'h33, 8'h22, 8'h11};
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = vals[i];
            tick();
        end
        push = 1'b0;
        n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL order_count: got %0d want 4", count); end
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1; tick();
            pop = 1'b0; tick();
            n_cmp++; if (data_out !== exp[i]) begin n_bad++; $display("FAIL order_pop%0d: got %h want %h", i, data_out, exp[i]); end
        end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL order_left: got %0d want 1", count); end
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL order_empty: got %b want 0", empty); end
        pop = 1'b1; tick(); pop = 1'b0;
        n_cmp++; if (data_out !== 8'h11) begin n_bad++; $display("FAIL order_last: got %h want 11", data_out); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL order_drained: got %b want 1", empty); end
    endtask

    task automatic test_full;
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h10 + 8'(i);
            tick();
        end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", full); end
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", count); end
        data_in = 8'hFF;
        tick();
        push = 1'b0;
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_ovf_count: got %0d want 8", count); end
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (data_out !== 8'h17 - 8'(i)) begin n_bad++; $display("FAIL full_pop%0d: got %h want %h", i, data_out, 8'h17 - 8'(i)); end
        end
        pop = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_drained: got %b want 1", empty); end
    endtask

    task automatic test_empty;
        pop = 1'b1; tick(); pop = 1'b0;
        n_cmp++; if (data_out !== 8'h10) begin n_bad++; $display("FAIL empty_hold: got %h want 10", data_out); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL empty_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL empty_flag: got %b want 1", empty); end
        push = 1'b1; data_in = 8'h5A; tick(); push = 1'b0;
        pop = 1'b1; tick(); pop = 1'b0;
        n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL empty_5a: got %h want 5a", data_out); end
    endtask

    task automatic test_simul;
        push = 1'b1;
        data_in = 8'hA1; tick();
        data_in = 8'hA2; tick();
        pop = 1'b1; data_in = 8'hB3; tick();
        push = 1'b0;
        n_cmp++; if (data_out !== 8'hA2) begin n_bad++; $display("FAIL simul_dout: got %h want a2", data_out); end
        n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL simul_count: got %0d want 2", count); end
        tick();
        n_cmp++; if (data_out !== 8'hB3) begin n_bad++; $display("FAIL simul_b3: got %h want b3", data_out); end
        tick();
        n_cmp++; if (data_out !== 8'hA1) begin n_bad++; $display("FAIL simul_a1: got %h want a1", data_out); end
        // Both requests on an empty stack act as a plain push.
        push = 1'b1; data_in = 8'h77; tick(); push = 1'b0;
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL simul_empty_count: got %0d want 1", count); end
        n_cmp++; if (data_out !== 8'hA1) begin n_bad++; $display("FAIL simul_empty_hold: got %h want a1", data_out); end
        tick(); pop = 1'b0;
        n_cmp++; if (data_out !== 8'h77) begin n_bad++; $display("FAIL simul_77: got %h want 77", data_out); end
    endtask

    task automatic test_replace_full;
        push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h20 + 8'(i);
            tick();
        end
        pop = 1'b1; data_in = 8'hCC; tick(); push = 1'b0;
        n_cmp++; if (data_out !== 8'h27) begin n_bad++; $display("FAIL repl_dout: got %h want 27", data_out); end
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL repl_count: got %0d want 8", count); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL repl_full: got %b want 1", full); end
        tick();
        n_cmp++; if (data_out !== 8'hCC) begin n_bad++; $display("FAIL repl_cc: got %h want cc", data_out); end
        tick(); pop = 1'b0;
        n_cmp++; if (data_out !== 8'h26) begin n_bad++; $display("FAIL repl_26: got %h want 26", data_out); end
        n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL repl_left: got %0d want 6", count); end
    endtask

    task automatic test_async_reset;
        reset = 1'b0; #2; reset = 1'b1;
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h31 + 8'(i);
            tick();
        end
        push = 1'b0;
        pop = 1'b1; tick(); pop = 1'b0;
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL arst_pre_count: got %0d want 3", count); end
        n_cmp++; if (data_out !== 8'h34) begin n_bad++; $display("FAIL arst_pre_dout: got %h want 34", data_out); end
        #3; reset = 1'b0; #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL arst_empty: got %b want 1", empty); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL arst_dout: got %h want 00", data_out); end
        #2; reset = 1'b1;
        push = 1'b1; data_in = 8'h42; tick(); push = 1'b0;
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL arst_first_push: got %0d want 1", count); end
        pop = 1'b1; tick(); pop = 1'b0;
        n_cmp++; if (data_out !== 8'h42) begin n_bad++; $display("FAIL arst_first_pop: got %h want 42", data_out); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL arst_drained: got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_empty();
        test_simul();
        test_replace_full();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
